pwm_fade_sequencer: RTL

//   Drives the PWM output pin (uo_out[7] at top level) and sequences its duty cycle.

---
 rtl/pwm_fade_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer: PWM generator with a duty-cycle fade sequencer.
// A command {target, step, interval} ramps the applied duty toward the target,
// one step every (interval+1) PWM periods. Duty only changes at period wrap.
// Optional feature: define PWM_FADE_DONE_IRQ_EN to add a sticky done_irq output
// and its irq_clr input.
module pwm_fade_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_target,
  input  logic [WIDTH-1:0] cfg_step,
  input  logic [DIV_W-1:0] cfg_interval,
  output logic             pwm,
  output logic [WIDTH-1:0] duty,
  output logic             busy,
  output logic             period_start
`ifdef PWM_FADE_DONE_IRQ_EN
  ,
  output logic             done_irq,
  input  logic             irq_clr
`endif
);

  localparam logic [WIDTH-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] duty_nxt_q;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] step_q;
  logic [DIV_W-1:0] ivl_q;
  logic [DIV_W-1:0] ivl_cnt_q;
  logic             pwm_q;
  logic             busy_q;
  logic             pstart_q;

  logic             wrap;
  logic             accept;
  logic             ramping;
  logic             step_now;
  logic             ivl_tick;
  logic             step_done;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_diff;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] dn_val;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] cfg_step_eff;
  state_e           accept_state;

  assign cfg_ready = ena & ~rst;
  assign accept    = cfg_valid & cfg_ready;
  assign wrap      = (cnt_q == CntMax) & ena;
  assign ramping   = (state_q != StIdle);

  // A new command pre-empts any step that would land on the same wrap.
  assign step_now  = wrap & ~accept & ramping & (ivl_cnt_q == ivl_q);
  assign ivl_tick  = wrap & ~accept & ramping & (ivl_cnt_q != ivl_q);
  assign step_done = step_now & (stepped == tgt_q);

  // Saturating step toward the target; one extra bit catches over/underflow.
  always_comb begin
    up_sum  = {1'b0, duty_nxt_q} + {1'b0, step_q};
    dn_diff = {1'b0, duty_nxt_q} - {1'b0, step_q};
    up_val  = (up_sum > {1'b0, tgt_q}) ? tgt_q : up_sum[WIDTH-1:0];
    dn_val  = (dn_diff[WIDTH] || (dn_diff[WIDTH-1:0] < tgt_q)) ? tgt_q : dn_diff[WIDTH-1:0];
    stepped = (state_q == StUp) ? up_val : dn_val;
  end

  // Decode an offered command: zero step means one, direction from current duty_nxt.
  always_comb begin
    cfg_step_eff = (cfg_step == '0) ? WIDTH'(1) : cfg_step;
    if (cfg_target > duty_nxt_q) begin
      accept_state = StUp;
    end else if (cfg_target < duty_nxt_q) begin
      accept_state = StDown;
    end else begin
      accept_state = StIdle;
    end
  end

  // Period counter, PWM comparator and ramp FSM; everything freezes while ena is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      duty_q     <= '0;
      duty_nxt_q <= '0;
      tgt_q      <= '0;
      step_q     <= '0;
      ivl_q      <= '0;
      ivl_cnt_q  <= '0;
      state_q    <= StIdle;
      pwm_q      <= 1'b0;
      busy_q     <= 1'b0;
      pstart_q   <= 1'b0;
    end else if (ena) begin
      cnt_q    <= cnt_q + WIDTH'(1);
      pwm_q    <= (cnt_q < duty_q);
      pstart_q <= (cnt_q == '0);
      // The comparator sees the post-step value from the first cycle of the new period.
      if (wrap) begin
        duty_q <= step_now ? stepped : duty_nxt_q;
      end
      if (accept) begin
        tgt_q     <= cfg_target;
        step_q    <= cfg_step_eff;
        ivl_q     <= cfg_interval;
        ivl_cnt_q <= '0;
        state_q   <= accept_state;
        busy_q    <= (accept_state != StIdle);
      end else if (step_now) begin
        duty_nxt_q <= stepped;
        ivl_cnt_q  <= '0;
        if (step_done) begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      end else if (ivl_tick) begin
        ivl_cnt_q <= ivl_cnt_q + DIV_W'(1);
      end
    end else begin
      pwm_q    <= 1'b0;
      pstart_q <= 1'b0;
    end
  end

`ifdef PWM_FADE_DONE_IRQ_EN
  logic done_irq_q;
  logic accept_done;

  assign accept_done = accept & (accept_state == StIdle);

  // Sticky completion flag; a new completion beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_irq_q <= 1'b0;
    end else if (step_done || accept_done) begin
      done_irq_q <= 1'b1;
    end else if (irq_clr) begin
      done_irq_q <= 1'b0;
    end
  end

  assign done_irq = done_irq_q;
`endif

  assign pwm          = pwm_q;
  assign duty         = duty_q;
  assign busy         = busy_q;
  assign period_start = pstart_q;

endmodule
